// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side program-counter controller for the RV64 core.
// It owns the PC and issues one instruction-memory request at a time.
// It holds each returned instruction for decode until decode accepts it.
// It applies control-flow redirects resolved in execute, shifting B/J immediates here.
// Optional feature: define PC_SEQ_JAL_PREDICT_EN to follow jal at fetch time.
// In that build, jal redirects from execute are then ignored.
module pc_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_inst,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [63:0] if_pc,
  input  logic        if_ready,
  input  logic        ex_valid,
  input  logic [1:0]  ex_kind,
  input  logic        ex_taken,
  input  logic [63:0] ex_pc,
  input  logic [63:0] ex_imm,
  input  logic [63:0] ex_rs1,
  output logic        flush,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_RST,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_FAULT
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] br_target;
  logic [63:0] jalr_target;
  logic [63:0] target;
  logic        redirect;
  logic        misaligned;
  logic [63:0] next_seq_pc;

  // The request address is always the PC being fetched.
  assign imem_req_addr = pc;

  // Decide whether execute is redirecting fetch, and compute where to.
  always_comb begin
    br_target   = ex_pc + (ex_imm << 1);
    jalr_target = (ex_rs1 + ex_imm) & ~64'h1;
    target      = (ex_kind == 2'b11) ? jalr_target : br_target;
    misaligned  = target[1];
    redirect    = 1'b0;
    if (ex_valid) begin
      case (ex_kind)
        2'b01:   redirect = ex_taken;
`ifdef PC_SEQ_JAL_PREDICT_EN
        2'b10:   redirect = 1'b0;
`else
        2'b10:   redirect = 1'b1;
`endif
        2'b11:   redirect = 1'b1;
        default: redirect = 1'b0;
      endcase
    end
  end

`ifdef PC_SEQ_JAL_PREDICT_EN
  logic [63:0] jal_imm;
  logic        is_jal;

  // Compute the PC after the held instruction, following a jal if one is held.
  always_comb begin
    jal_imm     = {{43{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20],
                   if_inst[30:21], 1'b0};
    is_jal      = (if_inst[6:0] == 7'b1101111);
    next_seq_pc = is_jal ? (if_pc + jal_imm) : (pc + 64'd4);
  end
`else
  // Compute the next straight-line PC.
  always_comb begin
    next_seq_pc = pc + 64'd4;
  end
`endif

  // Main fetch FSM; all outputs are registered and a redirect beats every other event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_RST;
      pc             <= RESET_PC;
      imem_req_valid <= 1'b0;
      if_valid       <= 1'b0;
      if_inst        <= NOP_INST;
      if_pc          <= RESET_PC;
      flush          <= 1'b0;
      fault          <= 1'b0;
    end else begin
      flush <= 1'b0;
      if (redirect && (state != S_FAULT)) begin
        flush    <= 1'b1;
        if_valid <= 1'b0;
        if (misaligned) begin
          state          <= S_FAULT;
          fault          <= 1'b1;
          imem_req_valid <= 1'b0;
        end else begin
          pc <= target;
          case (state)
            S_REQ: begin
              if (imem_req_ready) begin
                state          <= S_DRAIN;
                imem_req_valid <= 1'b0;
              end else begin
                state          <= S_REQ;
                imem_req_valid <= 1'b1;
              end
            end
            S_WAIT: begin
              if (imem_rsp_valid) begin
                state          <= S_REQ;
                imem_req_valid <= 1'b1;
              end else begin
                state          <= S_DRAIN;
                imem_req_valid <= 1'b0;
              end
            end
            S_DRAIN: begin
              state          <= S_DRAIN;
              imem_req_valid <= 1'b0;
            end
            default: begin
              state          <= S_REQ;
              imem_req_valid <= 1'b1;
            end
          endcase
        end
      end else begin
        case (state)
          S_RST: begin
            state          <= S_REQ;
            imem_req_valid <= 1'b1;
          end
          S_REQ: begin
            if (imem_req_ready) begin
              state          <= S_WAIT;
              imem_req_valid <= 1'b0;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              state    <= S_HOLD;
              if_valid <= 1'b1;
              if_inst  <= imem_rsp_inst;
              if_pc    <= pc;
            end
          end
          S_HOLD: begin
            if (if_ready) begin
              state          <= S_REQ;
              if_valid       <= 1'b0;
              imem_req_valid <= 1'b1;
              pc             <= next_seq_pc;
            end
          end
          S_DRAIN: begin
            if (imem_rsp_valid) begin
              state          <= S_REQ;
              imem_req_valid <= 1'b1;
            end
          end
          default: begin
            state          <= S_FAULT;
            imem_req_valid <= 1'b0;
            if_valid       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
